// File: rtl/led_sequencer.sv
// Active-low LED pattern sequencer: prescaled step ticks drive an OFF/CHASE/BOUNCE/BLINK
// pattern, with mode changes accepted by request/ack and applied on a tick boundary.
module led_sequencer #(
    parameter int N_LED    = 5,
    parameter int TICK_DIV = 12000000,
    parameter int DIV_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             mode_req,
    output logic             mode_ack,
    input  logic             pause,
    output logic             step,
    output logic [N_LED-1:0] led
);

    localparam int               POS_W    = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_CHASE  = 2'b01,
        ST_BOUNCE = 2'b10,
        ST_BLINK  = 2'b11
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [DIV_W-1:0] div_q,       div_d;
    logic [POS_W-1:0] pos_q,       pos_d;
    dir_e             dir_q,       dir_d;
    state_e           state_q,     state_d;
    state_e           pend_mode_q, pend_mode_d;
    logic             pending_q,   pending_d;
    logic             ack_q,       ack_d;
    logic             step_q,      step_d;
    logic [N_LED-1:0] led_q,       led_d;

    logic             tick;
    logic             apply;
    state_e           new_mode;
    logic [POS_W-1:0] pos_inc;

    // A request in the tick cycle itself bypasses the pending register.
    assign tick     = !pause && (div_q == DIV_LAST);
    assign apply    = tick && (pending_q || mode_req);
    assign new_mode = mode_req ? state_e'(mode) : pend_mode_q;
    assign pos_inc  = pos_q + POS_ONE;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the pre-edge values of its peers.
        if (!rst_n) begin
            div_q       <= '0;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            state_q     <= ST_OFF;
            pend_mode_q <= ST_OFF;
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
            step_q      <= 1'b0;
            led_q       <= '1;
        end else begin
            div_q       <= div_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            state_q     <= state_d;
            pend_mode_q <= pend_mode_d;
            pending_q   <= pending_d;
            ack_q       <= ack_d;
            step_q      <= step_d;
            led_q       <= led_d;
        end
    end

    // Next-state logic: prescaler, handshake and pattern advance
    always_comb begin
        // NOTE: every _d gets a hold default first, so no path can infer a latch.
        div_d       = div_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        state_d     = state_q;
        pend_mode_d = pend_mode_q;
        pending_d   = pending_q;
        ack_d       = 1'b0;
        step_d      = 1'b0;

        if (!pause) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end

        if (mode_req) begin
            pend_mode_d = state_e'(mode);
            pending_d   = 1'b1;
        end

        if (apply) begin
            state_d   = new_mode;
            pos_d     = '0;
            dir_d     = DIR_UP;
            pending_d = 1'b0;
            ack_d     = 1'b1;
            step_d    = 1'b1;
        end else if (tick) begin
            step_d = (state_q != ST_OFF);
            unique case (state_q)
                ST_OFF: begin
                    pos_d = '0;
                    dir_d = DIR_UP;
                end
                ST_CHASE: begin
                    pos_d = (pos_q >= POS_LAST) ? '0 : pos_inc;
                    dir_d = DIR_UP;
                end
                ST_BOUNCE: begin
                    if (pos_q > POS_LAST) begin
                        pos_d = '0;
                        dir_d = DIR_UP;
                    end else if (dir_q == DIR_UP) begin
                        if (pos_q == POS_LAST) begin
                            pos_d = POS_LAST - POS_ONE;
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_inc;
                            dir_d = (pos_inc == POS_LAST) ? DIR_DOWN : DIR_UP;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = POS_ONE;
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - POS_ONE;
                            dir_d = (pos_q == POS_ONE) ? DIR_UP : DIR_DOWN;
                        end
                    end
                end
                ST_BLINK: begin
                    pos_d = POS_W'(~pos_q[0]);
                    dir_d = DIR_UP;
                end
                default: begin
                    pos_d = '0;
                    dir_d = DIR_UP;
                end
            endcase
        end
    end

    // Output decode from next state; registered so the pins never glitch
    always_comb begin
        led_d = '1;
        unique case (state_d)
            ST_OFF: led_d = '1;
            ST_CHASE, ST_BOUNCE: begin
                for (int i = 0; i < N_LED; i++) begin
                    led_d[i] = (pos_d != POS_W'(i));
                end
            end
            ST_BLINK: led_d = pos_d[0] ? '1 : '0;
            default:  led_d = '1;
        endcase
    end

    assign mode_ack = ack_q;
    assign step     = step_q;
    assign led      = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: cycle-by-cycle vector table with hand-computed
// expectations, followed by a hand-written handshake and pause sequence.
module tb_led_sequencer;

    localparam int N_LED = 5;

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode;
    logic             mode_req;
    logic             mode_ack;
    logic             pause;
    logic             step;
    logic [N_LED-1:0] led;

    led_sequencer #(
        .N_LED   (N_LED),
        .TICK_DIV(4),
        .DIV_W   (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mode    (mode),
        .mode_req(mode_req),
        .mode_ack(mode_ack),
        .pause   (pause),
        .step    (step),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [1:0] mode;
        logic       req;
        logic       pause;
        logic [4:0] led;
        logic       step;
        logic       ack;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] last_led;
    int         checks;
    int         errors;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic [1:0] m, input logic q, input logic p,
                        input logic [4:0] l, input logic s, input logic a);
        vec_t v;
        v.rst_n = r;
        v.mode  = m;
        v.req   = q;
        v.pause = p;
        v.led   = l;
        v.step  = s;
        v.ack   = a;
        vecs.push_back(v);
        last_led = l;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) push(1'b1, 2'b00, 1'b0, 1'b0, last_led, 1'b0, 1'b0);
    endtask

    task automatic req(input logic [1:0] m);
        push(1'b1, m, 1'b1, 1'b0, last_led, 1'b0, 1'b0);
    endtask

    task automatic tick(input logic [4:0] l, input logic a);
        push(1'b1, 2'b00, 1'b0, 1'b0, l, 1'b1, a);
    endtask

    // Three quiet cycles then a plain pattern step
    task automatic period(input logic [4:0] l);
        idle(3);
        tick(l, 1'b0);
    endtask

    initial begin
        bit got;
        checks   = 0;
        errors   = 0;
        last_led = 5'b11111;
        rst_n    = 1'b0;
        mode     = 2'b00;
        mode_req = 1'b0;
        pause    = 1'b0;

        // Reset and idle OFF: ticks happen every 4th edge but OFF never steps
        for (int k = 0; k < 3; k++) push(1'b0, 2'b00, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0);
        idle(20);

        // CHASE
        req(2'b01); idle(2); tick(5'b11110, 1'b1);
        period(5'b11101); period(5'b11011); period(5'b10111); period(5'b01111); period(5'b11110);

        // BOUNCE: 0,1,2,3,4,3,2,1,0,1
        req(2'b10); idle(2); tick(5'b11110, 1'b1);
        period(5'b11101); period(5'b11011); period(5'b10111); period(5'b01111);
        period(5'b10111); period(5'b11011); period(5'b11101); period(5'b11110); period(5'b11101);

        // BLINK
        req(2'b11); idle(2); tick(5'b00000, 1'b1);
        period(5'b11111); period(5'b00000); period(5'b11111);

        // Pause with a BOUNCE request inside; divider held at 2, so tick two edges after release
        req(2'b01); idle(2); tick(5'b11110, 1'b1);
        period(5'b11101);
        idle(2);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) push(1'b1, 2'b10, 1'b1, 1'b1, 5'b11101, 1'b0, 1'b0);
            else        push(1'b1, 2'b00, 1'b0, 1'b1, 5'b11101, 1'b0, 1'b0);
        end
        idle(1); tick(5'b11110, 1'b1);
        period(5'b11101); period(5'b11011);

        // Two requests before one tick: latest wins, single ack
        req(2'b01); req(2'b11); idle(1); tick(5'b00000, 1'b1);
        period(5'b11111);

        // Same again but reset lands before the tick: pending discarded
        req(2'b01); req(2'b11);
        push(1'b0, 2'b00, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0);
        idle(8);

        // Request on the tick edge itself, then a same-mode restart
        idle(3);
        push(1'b1, 2'b01, 1'b1, 1'b0, 5'b11110, 1'b1, 1'b1);
        period(5'b11101);
        idle(3);
        push(1'b1, 2'b01, 1'b1, 1'b0, 5'b11110, 1'b1, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rst_n;
            mode     = vecs[i].mode;
            mode_req = vecs[i].req;
            pause    = vecs[i].pause;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_led", i),  8'(led),      8'(vecs[i].led));
            check($sformatf("v%0d_step", i), 8'(step),     8'(vecs[i].step));
            check($sformatf("v%0d_ack", i),  8'(mode_ack), 8'(vecs[i].ack));
        end

        // Hand sequence: bounded wait for the BLINK ack after a fresh reset
        rst_n    = 1'b0;
        mode_req = 1'b0;
        pause    = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mode     = 2'b11;
        mode_req = 1'b1;
        @(posedge clk);
        #1;
        mode_req = 1'b0;
        got      = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (mode_ack === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("hs_ack_seen", 8'(got), 8'd1);
        if (got) begin
            check("hs_ack_led",  8'(led),  8'b00000);
            check("hs_ack_step", 8'(step), 8'd1);
            @(posedge clk);
            #1;
            check("hs_ack_pulse", 8'(mode_ack), 8'd0);
        end

        // Long pause: LEDs frozen, no steps
        pause = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_step", k), 8'(step), 8'd0);
            check($sformatf("hold%0d_led", k),  8'(led),  8'b00000);
        end
        pause = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
